// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

   // Operand width, fixed at 16 by the 16-bit CLA adder.
   localparam int WIDTH = 16;

   // Number of RUN iterations: one per multiplier bit.
   localparam int ITER  = 16;

   // Width of the iteration counter (counts 0 .. ITER-1).
   localparam int CNT_W = 4;

   // Controller states (2-bit encoding).
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_seq_ctrl_cla.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second-level lookahead unit. Exposes group propagate/generate (pg/gg)
// so it can be cascaded into wider adders.
module cla_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout,
   output logic        pg,
   output logic        gg
);

   logic [15:0] bit_p;
   logic [15:0] bit_g;
   logic [3:0]  grp_p;
   logic [3:0]  grp_g;
   logic [4:0]  grp_c;

   // Sum of one 4-bit group given its carry-in, with in-group carries in
   // flattened lookahead form rather than rippling.
   function automatic logic [3:0] group_sum(input logic [3:0] p4,
                                            input logic [2:0] g3,
                                            input logic       ci);
      logic [3:0] c;
      c[0] = ci;
      c[1] = g3[0] | (p4[0] & ci);
      c[2] = g3[1] | (p4[1] & g3[0]) | (p4[1] & p4[0] & ci);
      c[3] = g3[2] | (p4[2] & g3[1]) | (p4[2] & p4[1] & g3[0])
           | (p4[2] & p4[1] & p4[0] & ci);
      return p4 ^ c;
   endfunction

   // Group generate: a carry leaves the group regardless of its carry-in.
   function automatic logic group_gen(input logic [3:0] p4, input logic [3:0] g4);
      return g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
           | (p4[3] & p4[2] & p4[1] & g4[0]);
   endfunction

   assign bit_p = a ^ b;
   assign bit_g = a & b;

   // Per-group propagate/generate and sums.
   for (genvar k = 0; k < 4; k++) begin : g_grp
      assign grp_p[k] = &bit_p[4*k +: 4];
      assign grp_g[k] = group_gen(bit_p[4*k +: 4], bit_g[4*k +: 4]);
      assign s[4*k +: 4] = group_sum(bit_p[4*k +: 4], bit_g[4*k +: 3], grp_c[k]);
   end

   // Second-level lookahead: group carries straight from cin.
   assign grp_c[0] = cin;
   assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
   assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
   assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
   assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

   assign pg   = &grp_p;
   assign gg   = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
   assign cout = grp_c[4];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential radix-2 shift-and-add unsigned multiplier, 16x16 -> 32.
// One CLA add per clock over 16 iterations; single operation in flight.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and never while rst is high);
// out_valid is high only in DONE, where p is held stable until out_ready.
// After an output transfer the block spends one cycle in IDLE before the
// next accept can happen.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mq_q,    mq_d;
   logic [WIDTH-1:0]   acc_q,   acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [2*WIDTH-1:0] p_q,     p_d;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               carry;
   logic [WIDTH-1:0]   acc_next;
   logic [WIDTH-1:0]   mq_next;
   logic               unused_pg;
   logic               unused_gg;
   logic               accept;
   logic               zero_op;

   // The multiplicand is gated by the current low multiplier bit.
   assign addend = mq_q[0] ? mcand_q : '0;

   cla_16 u_adder (
      .a    (acc_q),
      .b    (addend),
      .cin  (1'b0),
      .s    (sum),
      .cout (carry),
      .pg   (unused_pg),
      .gg   (unused_gg)
   );

   // The 17-bit {carry, sum} shifts right by one: carry enters the top of acc,
   // sum[0] enters the top of mq as the consumed multiplier bit leaves.
   assign acc_next = {carry, sum[WIDTH-1:1]};
   assign mq_next  = {sum[0], mq_q[WIDTH-1:1]};

   assign in_ready  = ~rst & (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign p         = p_q;
   assign accept    = in_valid & in_ready;
   assign zero_op   = ZERO_SKIP && ((a == '0) || (b == '0));

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      mq_d    = mq_q;
      acc_d   = acc_q;
      count_d = count_q;
      p_d     = p_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               mcand_d = a;
               mq_d    = b;
               acc_d   = '0;
               count_d = '0;
               if (zero_op) begin
                  state_d = S_DONE;
                  p_d     = '0;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            acc_d   = acc_next;
            mq_d    = mq_next;
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(ITER - 1)) begin
               state_d = S_DONE;
               p_d     = {acc_next, mq_next};
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         mq_q    <= '0;
         acc_q   <= '0;
         count_q <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mq_q    <= mq_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         p_q     <= p_d;
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: vector table plus hand sequences
// for backpressure, mid-run reset and back-to-back operation.
module tb_mult_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_ready;
   logic        sel_nz;

   logic        in_ready,  out_valid,  busy;
   logic [31:0] p;
   logic        nz_in_ready, nz_out_valid, nz_busy;
   logic [31:0] nz_p;

   logic        cur_in_ready, cur_out_valid, cur_busy;
   logic [31:0] cur_p;

   int total;
   int bad;

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   mult_seq_ctrl #(.WIDTH(16), .ZERO_SKIP(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid & ~sel_nz),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   mult_seq_ctrl #(.WIDTH(16), .ZERO_SKIP(1'b0)) dut_nz (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid & sel_nz),
      .in_ready  (nz_in_ready),
      .a         (a),
      .b         (b),
      .out_valid (nz_out_valid),
      .out_ready (out_ready),
      .p         (nz_p),
      .busy      (nz_busy)
   );

   assign cur_in_ready  = sel_nz ? nz_in_ready  : in_ready;
   assign cur_out_valid = sel_nz ? nz_out_valid : out_valid;
   assign cur_busy      = sel_nz ? nz_busy      : busy;
   assign cur_p         = sel_nz ? nz_p         : p;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      int          hold;
      bit          nz;
      logic [31:0] exp_p;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Wait (bounded) for the selected DUT to become ready, at a negedge.
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!cur_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready_wait"}, {31'd0, cur_in_ready}, 32'd1);
   endtask

   // Count negedges after the current posedge until out_valid (1 = next cycle).
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (cur_out_valid) break;
      end
      if (!cur_out_valid) lat = -1;
   endtask

   // One full operation with optional output backpressure of 'hold' cycles.
   task automatic run_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                         input int hold, input bit nz, input logic [31:0] exp_p,
                         input int exp_lat);
      int lat;
      sel_nz = nz;
      @(negedge clk);
      wait_ready(name);
      a = va; b = vb; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_valid(lat);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_p"}, cur_p, exp_p);
      for (int i = 0; i < hold; i++) begin
         check({name, "_hold_p"}, cur_p, exp_p);
         check({name, "_hold_valid"}, {31'd0, cur_out_valid}, 32'd1);
         check({name, "_hold_in_ready"}, {31'd0, cur_in_ready}, 32'd0);
         check({name, "_hold_busy"}, {31'd0, cur_busy}, 32'd1);
         a = 16'd1; b = 16'd1; in_valid = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check({name, "_post_valid"}, {31'd0, cur_out_valid}, 32'd0);
      check({name, "_post_in_ready"}, {31'd0, cur_in_ready}, 32'd1);
      @(negedge clk);
      check({name, "_post_busy"}, {31'd0, cur_busy}, 32'd0);
      check({name, "_post_p"}, cur_p, exp_p);
   endtask

   initial begin
      int lat;
      int spurious;
      total = 0; bad = 0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0; sel_nz = 1'b0;

      vecs[0] = '{16'h0003, 16'h0005, 0, 1'b0, 32'h0000000F, 17};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 0, 1'b0, 32'hFFFE0001, 17};
      vecs[2] = '{16'h0000, 16'h1234, 0, 1'b0, 32'h00000000, 1};
      vecs[3] = '{16'h0000, 16'h1234, 0, 1'b1, 32'h00000000, 17};
      vecs[4] = '{16'h1234, 16'h5678, 5, 1'b0, 32'h06260060, 17};
      vecs[5] = '{16'hFFFF, 16'h0000, 0, 1'b0, 32'h00000000, 1};
      vecs[6] = '{16'hFFFF, 16'h0001, 0, 1'b0, 32'h0000FFFF, 17};
      vecs[7] = '{16'h0001, 16'hFFFF, 2, 1'b0, 32'h0000FFFF, 17};
      vecs[8] = '{16'h00FF, 16'h0F0F, 0, 1'b0, 32'h000EFFF1, 17};
      vecs[9] = '{16'h8000, 16'h0002, 0, 1'b1, 32'h00010000, 17};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_p", p, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // Vector table.
      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].hold,
                vecs[i].nz, vecs[i].exp_p, vecs[i].exp_lat);
      end
      sel_nz = 1'b0;

      // Reset during the 8th RUN cycle discards the operation.
      @(negedge clk);
      a = 16'h00FF; b = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      check("mid_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b1;
      #1 check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_after_valid", {31'd0, out_valid}, 32'd0);
      check("mid_after_busy", {31'd0, busy}, 32'd0);
      check("mid_after_p", p, 32'd0);
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      check("mid_no_product", 32'(spurious), 32'd0);
      run_op("after_rst", 16'h0007, 16'h0009, 0, 1'b0, 32'h0000003F, 17);

      // Back-to-back with in_valid held high throughout.
      @(negedge clk);
      check("b2b_ready0", {31'd0, in_ready}, 32'd1);
      a = 16'h8000; b = 16'h0002; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 a = 16'h1234; b = 16'h5678;
      wait_valid(lat);
      check("b2b_lat1", 32'(lat), 32'd17);
      check("b2b_p1", p, 32'h00010000);
      @(posedge clk);
      @(negedge clk);
      check("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
      check("b2b_gap_ready", {31'd0, in_ready}, 32'd1);
      check("b2b_gap_p", p, 32'h00010000);
      @(posedge clk);
      wait_valid(lat);
      check("b2b_lat2", 32'(lat), 32'd17);
      check("b2b_p2", p, 32'h06260060);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("b2b_end_valid", {31'd0, out_valid}, 32'd0);
      check("b2b_end_busy", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
